// File: rtl/test_status_ctrl_if.sv
// Per-thread exit report bus feeding the end-of-test controller.
// One report per cycle, no back-pressure.
interface test_status_ctrl_if #(
    parameter int CH_W   = 2,
    parameter int CODE_W = 8
);
    logic              wr_en_i;
    logic [CH_W-1:0]   wr_ch_i;
    logic [CODE_W-1:0] wr_code_i;

    modport master (
        output wr_en_i,
        output wr_ch_i,
        output wr_code_i
    );

    modport slave (
        input wr_en_i,
        input wr_ch_i,
        input wr_code_i
    );
endinterface

// File: rtl/test_status_ctrl.sv
// Multi-channel end-of-test controller: per-thread pass/fail reports,
// cycle watchdog and aggregate exit status for sim/FPGA runs.
module test_status_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int CODE_W      = 8,
    parameter int TIMEOUT_W   = 32,
    parameter int REQUIRE_ALL = 1,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    test_status_ctrl_if.slave    rpt,
    output logic                 eoc_o,
    output logic                 timeout_o,
    output logic [1:0]           exit_status_o,
    output logic [NUM_CH-1:0]    done_mask_o,
    output logic [NUM_CH-1:0]    fail_mask_o,
    output logic [CH_W-1:0]      first_fail_ch_o,
    output logic [CODE_W-1:0]    first_fail_code_o,
    output logic                 err_o,
    output logic [TIMEOUT_W-1:0] elapsed_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    state_t               r_state;
    logic [TIMEOUT_W-1:0] r_timeout_q;
    logic [NUM_CH-1:0]    r_done;
    logic [NUM_CH-1:0]    r_fail;
    logic [CH_W-1:0]      r_ff_ch;
    logic [CODE_W-1:0]    r_ff_code;
    logic                 r_err;
    logic [TIMEOUT_W-1:0] r_elapsed;

    state_t               w_state_nx;
    logic [TIMEOUT_W-1:0] w_timeout_nx;
    logic [NUM_CH-1:0]    w_done_nx;
    logic [NUM_CH-1:0]    w_fail_nx;
    logic [CH_W-1:0]      w_ff_ch_nx;
    logic [CODE_W-1:0]    w_ff_code_nx;
    logic                 w_err_nx;
    logic [TIMEOUT_W-1:0] w_elapsed_nx;
    logic                 w_valid;
    logic [NUM_CH-1:0]    w_sel;
    logic                 w_dup;
    logic                 w_cmp;
    logic                 w_hit;

    always_comb begin
        w_state_nx   = r_state;
        w_timeout_nx = r_timeout_q;
        w_done_nx    = r_done;
        w_fail_nx    = r_fail;
        w_ff_ch_nx   = r_ff_ch;
        w_ff_code_nx = r_ff_code;
        w_err_nx     = r_err;
        w_elapsed_nx = r_elapsed;
        w_valid      = (int'(rpt.wr_ch_i) < NUM_CH);
        w_sel        = w_valid ? (ONE << rpt.wr_ch_i) : '0;
        w_dup        = |(w_sel & r_done);
        w_cmp        = 1'b0;
        w_hit        = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start_i) begin
                    w_state_nx   = S_RUN;
                    w_timeout_nx = timeout_i;
                    w_done_nx    = '0;
                    w_fail_nx    = '0;
                    w_ff_ch_nx   = '0;
                    w_ff_code_nx = '0;
                    w_err_nx     = 1'b0;
                    w_elapsed_nx = '0;
                end
            end
            S_RUN: begin
                if (!(&r_elapsed))
                    w_elapsed_nx = r_elapsed + 1'b1;
                if (rpt.wr_en_i) begin
                    if (!w_valid || w_dup) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_done_nx = r_done | w_sel;
                        if (rpt.wr_code_i != '0) begin
                            w_fail_nx = r_fail | w_sel;
                            if (r_fail == '0) begin
                                w_ff_ch_nx   = rpt.wr_ch_i;
                                w_ff_code_nx = rpt.wr_code_i;
                            end
                        end
                    end
                end
                w_cmp = (REQUIRE_ALL != 0) ? (&w_done_nx)
                                           : (|w_done_nx);
                // unsaturated compare so an all-ones limit can still fire
                w_hit = (r_timeout_q != '0) &&
                        (({1'b0, r_elapsed} + 1'b1) ==
                         {1'b0, r_timeout_q});
                if (w_cmp)
                    w_state_nx = S_DONE;
                else if (w_hit)
                    w_state_nx = S_TIMEOUT;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timeout_q <= '0;
            r_done      <= '0;
            r_fail      <= '0;
            r_ff_ch     <= '0;
            r_ff_code   <= '0;
            r_err       <= 1'b0;
            r_elapsed   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_timeout_q <= w_timeout_nx;
            r_done      <= w_done_nx;
            r_fail      <= w_fail_nx;
            r_ff_ch     <= w_ff_ch_nx;
            r_ff_code   <= w_ff_code_nx;
            r_err       <= w_err_nx;
            r_elapsed   <= w_elapsed_nx;
        end
    end

    assign eoc_o             = (r_state == S_DONE) ||
                               (r_state == S_TIMEOUT);
    assign timeout_o         = (r_state == S_TIMEOUT);
    assign exit_status_o     = (timeout_o || r_err) ? 2'b11 :
                               (r_fail != '0)       ? 2'b01 : 2'b00;
    assign done_mask_o       = r_done;
    assign fail_mask_o       = r_fail;
    assign first_fail_ch_o   = r_ff_ch;
    assign first_fail_code_o = r_ff_code;
    assign err_o             = r_err;
    assign elapsed_o         = r_elapsed;

endmodule

// File: tb/tb_test_status_ctrl.sv
// Bench for test_status_ctrl: vector table plus hand sequences,
// expected outputs queued at drive time and popped after each edge.
module tb_test_status_ctrl;

    typedef struct packed {
        logic        eoc;
        logic        to;
        logic [1:0]  st;
        logic [2:0]  done;
        logic [2:0]  fail;
        logic        err;
        logic [1:0]  ffch;
        logic [7:0]  ffc;
        logic [31:0] el;
    } exp_t;

    typedef struct packed {
        logic        r;
        logic        s;
        logic [31:0] t;
        logic        w;
        logic [1:0]  ch;
        logic [7:0]  code;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] tmo0 = '0, tmo1 = '0;

    test_status_ctrl_if #(.CH_W(2), .CODE_W(8)) if0 ();
    test_status_ctrl_if #(.CH_W(2), .CODE_W(8)) if1 ();

    logic        eoc0, to0, err0, eoc1, to1, err1;
    logic [1:0]  st0, st1, ffch0, ffch1;
    logic [2:0]  done0, done1, fail0, fail1;
    logic [7:0]  ffc0, ffc1;
    logic [31:0] el0, el1;

    test_status_ctrl #(.NUM_CH(3), .CODE_W(8), .TIMEOUT_W(32),
                       .REQUIRE_ALL(1)) u0 (
        .clk(clk), .rst(rst), .start_i(start0), .timeout_i(tmo0),
        .rpt(if0.slave), .eoc_o(eoc0), .timeout_o(to0),
        .exit_status_o(st0), .done_mask_o(done0),
        .fail_mask_o(fail0), .first_fail_ch_o(ffch0),
        .first_fail_code_o(ffc0), .err_o(err0), .elapsed_o(el0)
    );

    test_status_ctrl #(.NUM_CH(3), .CODE_W(8), .TIMEOUT_W(32),
                       .REQUIRE_ALL(0)) u1 (
        .clk(clk), .rst(rst), .start_i(start1), .timeout_i(tmo1),
        .rpt(if1.slave), .eoc_o(eoc1), .timeout_o(to1),
        .exit_status_o(st1), .done_mask_o(done1),
        .fail_mask_o(fail1), .first_fail_ch_o(ffch1),
        .first_fail_code_o(ffc1), .err_o(err1), .elapsed_o(el1)
    );

    exp_t  q[$];
    string nq[$];
    vec_t  tbl[$];
    int    checks   = 0;
    int    failures = 0;
    bit    sel      = 1'b0;

    function automatic exp_t mk(input int eoc, input int to,
                                input int st, input int d,
                                input int f, input int e,
                                input int fch, input int fc,
                                input int el);
        exp_t r;
        r.eoc  = 1'(eoc);
        r.to   = 1'(to);
        r.st   = 2'(st);
        r.done = 3'(d);
        r.fail = 3'(f);
        r.err  = 1'(e);
        r.ffch = 2'(fch);
        r.ffc  = 8'(fc);
        r.el   = 32'(el);
        return r;
    endfunction

    function automatic vec_t mv(input int r, input int s, input int t,
                                input int w, input int ch,
                                input int code, input exp_t e);
        vec_t v;
        v.r    = 1'(r);
        v.s    = 1'(s);
        v.t    = 32'(t);
        v.w    = 1'(w);
        v.ch   = 2'(ch);
        v.code = 8'(code);
        v.e    = e;
        return v;
    endfunction

    function automatic exp_t obs();
        exp_t g;
        if (sel)
            g = {eoc1, to1, st1, done1, fail1, err1, ffch1, ffc1, el1};
        else
            g = {eoc0, to0, st0, done0, fail0, err0, ffch0, ffc0, el0};
        return g;
    endfunction

    task automatic compare();
        exp_t  e;
        exp_t  g;
        string n;
        e = q.pop_front();
        n = nq.pop_front();
        g = obs();
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, g, e);
        end
    endtask

    task automatic drive(input string nm, input vec_t v);
        @(negedge clk);
        rst          = v.r;
        start0       = 1'b0;
        start1       = 1'b0;
        tmo0         = '0;
        tmo1         = '0;
        if0.wr_en_i  = 1'b0;
        if0.wr_ch_i  = '0;
        if0.wr_code_i = '0;
        if1.wr_en_i  = 1'b0;
        if1.wr_ch_i  = '0;
        if1.wr_code_i = '0;
        if (sel) begin
            start1        = v.s;
            tmo1          = v.t;
            if1.wr_en_i   = v.w;
            if1.wr_ch_i   = v.ch;
            if1.wr_code_i = v.code;
        end else begin
            start0        = v.s;
            tmo0          = v.t;
            if0.wr_en_i   = v.w;
            if0.wr_ch_i   = v.ch;
            if0.wr_code_i = v.code;
        end
        q.push_back(v.e);
        nq.push_back(nm);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        if0.wr_en_i = 1'b0;
        if0.wr_ch_i = '0;
        if0.wr_code_i = '0;
        if1.wr_en_i = 1'b0;
        if1.wr_ch_i = '0;
        if1.wr_code_i = '0;

        // reset
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        // all pass
        tbl.push_back(mv(0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 0, mk(0,0,0,1,0,0,0,0,1)));
        tbl.push_back(mv(0, 0, 0, 1, 2, 0, mk(0,0,0,5,0,0,0,0,2)));
        tbl.push_back(mv(0, 0, 0, 1, 1, 0, mk(1,0,0,7,0,0,0,0,3)));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, mk(1,0,0,7,0,0,0,0,3)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 9, mk(1,0,0,7,0,0,0,0,3)));
        // failures, first-failure latch
        tbl.push_back(mv(0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 0, 0, 1, 1, 5, mk(0,0,1,2,2,0,1,5,1)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 7, mk(0,0,1,3,3,0,1,5,2)));
        tbl.push_back(mv(0, 0, 0, 1, 2, 0, mk(1,0,1,7,3,0,1,5,3)));
        // protocol errors
        tbl.push_back(mv(0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 3, mk(0,0,1,1,1,0,0,3,1)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 0, mk(0,0,3,1,1,1,0,3,2)));
        tbl.push_back(mv(0, 0, 0, 1, 3, 0, mk(0,0,3,1,1,1,0,3,3)));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, mk(0,0,3,1,1,1,0,3,4)));
        tbl.push_back(mv(0, 0, 0, 1, 1, 0, mk(0,0,3,3,1,1,0,3,5)));
        tbl.push_back(mv(0, 0, 0, 1, 2, 0, mk(1,0,3,7,1,1,0,3,6)));
        // restart from DONE, then reset mid-run and fresh run
        tbl.push_back(mv(0, 1, 0, 1, 1, 4, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 5, mk(0,0,1,1,1,0,0,5,1)));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        tbl.push_back(mv(0, 0, 0, 1, 1, 0, mk(0,0,0,2,0,0,0,0,1)));
        tbl.push_back(mv(0, 0, 0, 1, 0, 0, mk(0,0,0,3,0,0,0,0,2)));
        tbl.push_back(mv(0, 0, 0, 1, 2, 0, mk(1,0,0,7,0,0,0,0,3)));

        foreach (tbl[i])
            drive($sformatf("vec%0d", i), tbl[i]);

        // watchdog: T=20, only ch0 reports, start in RUN ignored
        drive("to_start", mv(0, 1, 20, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        drive("to_ch0", mv(0, 0, 0, 1, 0, 0, mk(0,0,0,1,0,0,0,0,1)));
        for (int k = 2; k < 20; k++)
            drive($sformatf("to_run%0d", k),
                  mv(0, (k == 2) ? 1 : 0, (k == 2) ? 5 : 0, 0, 0, 0,
                     mk(0,0,0,1,0,0,0,0,k)));
        drive("to_fire", mv(0, 0, 0, 0, 0, 0, mk(1,1,3,1,0,0,0,0,20)));
        drive("to_hold", mv(0, 0, 0, 1, 1, 0, mk(1,1,3,1,0,0,0,0,20)));

        // completion on the same edge the watchdog would fire
        drive("co_start", mv(0, 1, 10, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        drive("co_ch0", mv(0, 0, 0, 1, 0, 0, mk(0,0,0,1,0,0,0,0,1)));
        drive("co_ch1", mv(0, 0, 0, 1, 1, 0, mk(0,0,0,3,0,0,0,0,2)));
        for (int k = 3; k < 10; k++)
            drive($sformatf("co_run%0d", k),
                  mv(0, 0, 0, 0, 0, 0, mk(0,0,0,3,0,0,0,0,k)));
        drive("co_last", mv(0, 0, 0, 1, 2, 0, mk(1,0,0,7,0,0,0,0,10)));

        // first-report completion instance
        sel = 1'b1;
        drive("any_start", mv(0, 1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0)));
        drive("any_idle", mv(0, 0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1)));
        drive("any_ch2", mv(0, 0, 0, 1, 2, 0, mk(1,0,0,4,0,0,0,0,2)));
        drive("any_hold", mv(0, 0, 0, 1, 0, 0, mk(1,0,0,4,0,0,0,0,2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
